// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_HOLD    = 3'd2,
      ST_DISCARD = 3'd3,
      ST_FAULT   = 3'd4
   } fetch_state_t;

   localparam logic [3:0]  FETCH_WSTRB_READ = 4'b0000;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;

   // True when a byte address is not on a 32-bit word boundary.
   function automatic logic addr_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch master: holds the PC, issues one BRAM word read at a
// time and hands each word to decode over a valid/ready handshake.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect
// traps into a sticky fault state; otherwise redirect_pc[1:0] is ignored).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | bus idle for one cycle, next edge launches a request at pc
// REQ     | request at pc outstanding, waiting for mem_ready
// HOLD    | fetched word presented to decode, waiting for inst_ready
// DISCARD | redirected while a request was in flight; drain and drop it
// FAULT   | misaligned redirect seen; fetch stopped until reset
import fetch_pkg::*;

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        fetch_fault
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         mem_valid_q, mem_valid_d;
   logic [31:0]  mem_addr_q, mem_addr_d;
   logic         inst_valid_q, inst_valid_d;
   logic [31:0]  inst_data_q, inst_data_d;
   logic [31:0]  inst_pc_q, inst_pc_d;
   logic         fault_q, fault_d;
   logic         fault_pend_q, fault_pend_d;

   logic [31:0]  redir_pc;
   logic         redir_bad;
   logic [31:0]  pc_next_seq;
   logic [31:0]  drain_pc;
   logic         drain_pend;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redir_pc  = redirect_pc;
   assign redir_bad = addr_misaligned(redirect_pc);
`else
   // Low address bits are dropped so every redirect lands on a word.
   logic unused_redir_lsb;
   assign redir_pc         = {redirect_pc[31:2], 2'b00};
   assign redir_bad        = 1'b0;
   assign unused_redir_lsb = ^redirect_pc[1:0];
`endif

   // Address arithmetic wraps modulo 2^32 by construction.
   assign pc_next_seq = pc_q + PC_STEP;

   // Next-state decode: redirects take priority over every other event.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      mem_valid_d  = mem_valid_q;
      mem_addr_d   = mem_addr_q;
      inst_valid_d = inst_valid_q;
      inst_data_d  = inst_data_q;
      inst_pc_d    = inst_pc_q;
      fault_d      = fault_q;
      fault_pend_d = fault_pend_q;
      drain_pc     = pc_q;
      drain_pend   = fault_pend_q;

      case (state_q)
         ST_IDLE: begin
            if (redirect_valid && redir_bad) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
            end else if (redirect_valid) begin
               pc_d        = redir_pc;
               mem_valid_d = 1'b1;
               mem_addr_d  = redir_pc;
               state_d     = ST_REQ;
            end else begin
               mem_valid_d = 1'b1;
               mem_addr_d  = pc_q;
               state_d     = ST_REQ;
            end
         end

         ST_REQ: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               if (redirect_valid && redir_bad) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end else if (redirect_valid) begin
                  // Word for the old path is dropped; relaunch after one idle bus cycle.
                  pc_d    = redir_pc;
                  state_d = ST_IDLE;
               end else begin
                  inst_valid_d = 1'b1;
                  inst_data_d  = mem_rdata;
                  inst_pc_d    = pc_q;
                  state_d      = ST_HOLD;
               end
            end else if (redirect_valid) begin
               // The bus request cannot be withdrawn, so remember where to go next.
               fault_pend_d = redir_bad;
               if (!redir_bad) begin
                  pc_d = redir_pc;
               end
               state_d = ST_DISCARD;
            end
         end

         ST_HOLD: begin
            if (redirect_valid) begin
               inst_valid_d = 1'b0;
               if (redir_bad) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end else begin
                  pc_d        = redir_pc;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = redir_pc;
                  state_d     = ST_REQ;
               end
            end else if (inst_ready) begin
               inst_valid_d = 1'b0;
               pc_d         = pc_next_seq;
               mem_valid_d  = 1'b1;
               mem_addr_d   = pc_next_seq;
               state_d      = ST_REQ;
            end
         end

         ST_DISCARD: begin
            if (redirect_valid) begin
               drain_pend = redir_bad;
               if (!redir_bad) begin
                  drain_pc = redir_pc;
               end
            end
            pc_d         = drain_pc;
            fault_pend_d = drain_pend;
            if (mem_ready) begin
               mem_valid_d  = 1'b0;
               fault_pend_d = 1'b0;
               if (drain_pend) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_FAULT: begin
            mem_valid_d  = 1'b0;
            inst_valid_d = 1'b0;
         end

         default: begin
            state_d      = ST_IDLE;
            mem_valid_d  = 1'b0;
            inst_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; every output comes straight from a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= RESET_PC;
         inst_valid_q <= 1'b0;
         inst_data_q  <= 32'h0;
         inst_pc_q    <= 32'h0;
         fault_q      <= 1'b0;
         fault_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         mem_valid_q  <= mem_valid_d;
         mem_addr_q   <= mem_addr_d;
         inst_valid_q <= inst_valid_d;
         inst_data_q  <= inst_data_d;
         inst_pc_q    <= inst_pc_d;
         fault_q      <= fault_d;
         fault_pend_q <= fault_pend_d;
      end
   end

   assign mem_valid   = mem_valid_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = 32'h0;
   assign mem_wstrb   = FETCH_WSTRB_READ;
   assign inst_valid  = inst_valid_q;
   assign inst_data   = inst_data_q;
   assign inst_pc     = inst_pc_q;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: BRAM responder, transaction-level reference
// model with a per-cycle compare, directed scenarios and a random phase.
module tb_instr_fetch_unit;

`ifdef FETCH_MISALIGN_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = 32'h0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        fetch_fault;

   int total = 0;
   int bad   = 0;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   // Memory image: words 0..3 = 0x33, word 4 = 0x6F, hashed content elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'd16) return 32'h0000_0033;
      if (a < 32'd20) return 32'h0000_006F;
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // BRAM responder: ready pulse after the request has been up for lat cycles.
   bit lat_rand = 1'b0;
   int lat = 4;
   int cnt = 0;
   always @(posedge clk) begin
      #2;
      if (mem_valid) begin
         if (cnt == 0) lat = lat_rand ? int'($urandom_range(1, 6)) : 4;
         cnt++;
      end else begin
         cnt = 0;
      end
      mem_ready = mem_valid && (cnt == lat);
      mem_rdata = mem_ready ? mem_word(mem_addr) : $urandom;
      if (mem_ready) cnt = 0;
   end

   // Reference model: bus request, held instruction, pending drop, fault.
   logic        m_mv, m_iv, m_fault, m_drop, m_fpend;
   logic [31:0] m_addr, m_ipc, m_idata, m_next;
   logic [31:0] acc_pc[$];
   logic [31:0] acc_data[$];

   task automatic model_reset();
      m_mv = 0; m_iv = 0; m_fault = 0; m_drop = 0; m_fpend = 0;
      m_addr = 0; m_ipc = 0; m_idata = 0; m_next = 0;
   endtask

   task automatic model_step(input logic mr, input logic rv_in, input logic [31:0] rp_in,
                             input logic ir);
      logic        rv, mis;
      logic [31:0] rp;
      rv  = rv_in && !m_fault;
      rp  = CHK_EN ? rp_in : {rp_in[31:2], 2'b00};
      mis = rv && CHK_EN && (rp_in[1:0] != 2'b00);
      if (m_fault) return;
      if (m_mv) begin
         if (mr) begin
            m_mv = 0;
            if (rv) begin
               if (mis) m_fault = 1; else m_next = rp;
            end else if (m_drop) begin
               if (m_fpend) m_fault = 1;
            end else begin
               m_iv = 1; m_ipc = m_addr; m_idata = mem_word(m_addr);
            end
            m_drop = 0; m_fpend = 0;
         end else if (rv) begin
            m_drop  = 1;
            m_fpend = mis;
            if (!mis) m_next = rp;
         end
      end else if (m_iv) begin
         if (rv) begin
            m_iv = 0;
            if (mis) m_fault = 1;
            else begin m_mv = 1; m_addr = rp; end
         end else if (ir) begin
            acc_pc.push_back(m_ipc);
            acc_data.push_back(m_idata);
            m_iv = 0; m_mv = 1; m_addr = m_ipc + 32'd4;
         end
      end else begin
         if (rv && mis) m_fault = 1;
         else begin m_mv = 1; m_addr = rv ? rp : m_next; end
      end
   endtask

   // Model update on each edge, DUT compare 1 time unit later.
   always @(posedge clk) begin
      if (reset) model_reset();
      else model_step(mem_ready, redirect_valid, redirect_pc, inst_ready);
      #1;
      if (!reset) begin
         chk("cyc_mem_valid", {31'h0, mem_valid}, {31'h0, m_mv});
         chk("cyc_inst_valid", {31'h0, inst_valid}, {31'h0, m_iv});
         chk("cyc_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
         chk("cyc_wr_tie", {mem_wdata[27:0], mem_wstrb}, 32'h0);
         if (m_mv) chk("cyc_mem_addr", mem_addr, m_addr);
         if (m_iv) begin
            chk("cyc_inst_pc", inst_pc, m_ipc);
            chk("cyc_inst_data", inst_data, m_idata);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1; redirect_valid = 0;
      @(negedge clk);
      reset = 0;
   endtask

   task automatic wait_inst(input string nm);
      int n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!inst_valid && n < 300);
      if (!inst_valid) chk({nm, "_timeout"}, 32'h0, 32'h1);
   endtask

   logic [31:0] exp_seq [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

   initial begin
      reset = 1; redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
      reset = 0;

      // First fetch after reset release
      @(posedge clk); #1;
      chk("t1_mem_valid", {31'h0, mem_valid}, 32'h1);
      chk("t1_mem_addr", mem_addr, 32'h0);
      repeat (4) @(posedge clk); #1;
      chk("t1_inst_valid", {31'h0, inst_valid}, 32'h1);
      chk("t1_inst_data", inst_data, 32'h33);
      chk("t1_inst_pc", inst_pc, 32'h0);

      // Decode stalls for 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("t3_hold_valid", {31'h0, inst_valid}, 32'h1);
         chk("t3_hold_pc", inst_pc, 32'h0);
         chk("t3_hold_data", inst_data, 32'h33);
         chk("t3_hold_bus", {31'h0, mem_valid}, 32'h0);
      end

      // Streaming with decode always ready
      @(negedge clk);
      acc_pc.delete(); acc_data.delete();
      inst_ready = 1;
      begin
         int n = 0, low = 0;
         bit seen = 0;
         while (acc_pc.size() < 5 && n < 300) begin
            @(posedge clk); #1; n++;
            if (mem_valid) begin
               if (seen && low != 0) chk("t2_gap_len", low, 32'd1);
               seen = 1; low = 0;
            end else begin
               low++;
            end
         end
      end
      if (acc_pc.size() < 5) chk("t2_timeout", acc_pc.size(), 32'd5);
      else begin
         for (int i = 0; i < 5; i++) chk("t2_pc_seq", acc_pc[i], exp_seq[i]);
         chk("t2_data_10", acc_data[4], 32'h6F);
      end

      // Redirect two cycles into the fetch of 0x4
      do_reset();
      begin
         int n = 0;
         do begin @(posedge clk); #1; n++; end
         while (!(mem_valid && mem_addr == 32'h4) && n < 100);
      end
      @(negedge clk);
      @(negedge clk);
      redirect_valid = 1; redirect_pc = 32'h10;
      @(negedge clk);
      redirect_valid = 0;
      wait_inst("t4");
      chk("t4_inst_pc", inst_pc, 32'h10);
      chk("t4_inst_data", inst_data, 32'h6F);

      // Redirect together with the handshake, then reset mid-request
      do_reset();
      inst_ready = 0;
      wait_inst("t5a");
      @(negedge clk);
      inst_ready = 1; redirect_valid = 1; redirect_pc = 32'h8;
      @(negedge clk);
      inst_ready = 0; redirect_valid = 0;
      wait_inst("t5b");
      chk("t5_inst_pc", inst_pc, 32'h8);
      chk("t5_inst_data", inst_data, 32'h33);
      @(negedge clk);
      inst_ready = 1;
      @(posedge clk); #3;
      reset = 1;
      #1;
      chk("t5_rst_mem_valid", {31'h0, mem_valid}, 32'h0);
      chk("t5_rst_mem_addr", mem_addr, 32'h0);
      chk("t5_rst_inst_valid", {31'h0, inst_valid}, 32'h0);
      chk("t5_rst_inst_pc", inst_pc, 32'h0);
      chk("t5_rst_inst_data", inst_data, 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      @(posedge clk); #1;
      chk("t5_restart_valid", {31'h0, mem_valid}, 32'h1);
      chk("t5_restart_addr", mem_addr, 32'h0);

      // Misaligned redirect
      do_reset();
      inst_ready = 1;
      wait_inst("t6a");
      @(negedge clk);
      redirect_valid = 1; redirect_pc = 32'h6;
      @(negedge clk);
      redirect_valid = 0;
      if (CHK_EN) begin
         repeat (12) @(posedge clk);
         #1;
         chk("t6_fault", {31'h0, fetch_fault}, 32'h1);
         chk("t6_no_req", {31'h0, mem_valid}, 32'h0);
      end else begin
         wait_inst("t6b");
         chk("t6_inst_pc", inst_pc, 32'h4);
         chk("t6_fault", {31'h0, fetch_fault}, 32'h0);
      end

      // Wrap at the top of the address space
      do_reset();
      inst_ready = 0;
      wait_inst("tw_a");
      @(negedge clk);
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 0;
      wait_inst("tw_b");
      chk("tw_top_pc", inst_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      inst_ready = 1;
      @(negedge clk);
      inst_ready = 0;
      wait_inst("tw_c");
      chk("tw_wrap_pc", inst_pc, 32'h0);

      // Random traffic against the model
      lat_rand = 1;
      for (int seg = 0; seg < 4; seg++) begin
         do_reset();
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            inst_ready     = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 19))
               0:       redirect_pc = 32'hFFFF_FFFC;
               1:       redirect_pc = (seg == 3) ? {24'h0, 6'($urandom_range(0, 63)), 2'b10}
                                                 : 32'h14;
               default: redirect_pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
         end
      end
      @(negedge clk);
      redirect_valid = 0; inst_ready = 0;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
